stream_fifo: RTL
================

Name: stream_fifo

Overview:
- Parametrised synchronous FIFO with valid/ready handshake on both sides, for stream buffering between codec pipeline stages.
- Generalises the basic FIFO:
  - any depth, including non-power-of-two;
  - optional registered output stage;
  - occupancy count;
  - registered almost-full / almost-empty flags;
  - synchronous flush.

Parameters:
- DATA_WIDTH, 8, payload width in bits.
- DEPTH, 16, entry capacity; any integer >= 2, power of two not required.
- OUT_REG, 0, 0 = dout read combinationally from storage; 1 = dout driven from a flop.
- AF_LVL, DEPTH-2, almost_full asserts when count >= AF_LVL; legal range 1..DEPTH.
- AE_LVL, 1, almost_empty asserts when count <= AE_LVL; legal range 0..DEPTH-1.
- Derived localparams: AW = $clog2(DEPTH); CW = $clog2(DEPTH+1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset. One clock; reset is synchronous and active-high.
- flush  in  1  synchronous discard of all contents.
- din  in  DATA_WIDTH  write data.
- din_vld  in  1  write request.
- din_rdy  out  1  space available; write occurs on din_vld & din_rdy.
- dout  out  DATA_WIDTH  read data, meaningful only while dout_vld = 1.
- dout_vld  out  1  head entry present.
- dout_rdy  in  1  consumer accept; pop occurs on dout_vld & dout_rdy.
- count  out  CW  entries held (0..DEPTH).
- almost_full  out  1  registered, count >= AF_LVL.
- almost_empty  out  1  registered, count <= AE_LVL.

Behaviour:
Storage and pointers
- Storage is DEPTH x DATA_WIDTH, with write pointer wp and read pointer rp, each AW bits.
- Each pointer increments on its handshake and wraps from DEPTH-1 to 0. There is no MSB-toggle scheme; full/empty derive from count only.

Count
- count is a register.
- Update rule: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop or on neither.
- count never exceeds DEPTH and never goes below 0.

Ready
- din_rdy = (count != DEPTH) & !flush, combinational from registers and flush.
- When full, a same-cycle pop does NOT enable a push. There is no write-through; din_rdy stays 0 that cycle.

OUT_REG = 0
- dout_vld = (count != 0) & !flush.
- dout = mem[rp].
- Latency: a word pushed at edge N is visible on dout with dout_vld = 1 in the cycle after edge N.

OUT_REG = 1
- A one-entry output register is prefetched from storage whenever it is empty, or being popped, and storage holds data.
- The output register counts as one of the DEPTH slots; total capacity remains DEPTH.
- dout and dout_vld come straight from flops. dout_vld is forced 0 while flush = 1.
- Latency from push at edge N to dout_vld = 1: two cycles (visible after edge N+1).
- Back-to-back pops sustain one word per cycle while data is available.
- count reflects accepted minus popped words, so count may be 1 while dout_vld is still 0 during the prefetch cycle.

Ordering and data integrity
- Strict FIFO order across pointer wrap.
- dout must hold stable while dout_vld = 1 and dout_rdy = 0.

Flags
- almost_full and almost_empty are registered, computed from next-count, so they change on the same edge as count.

Flush
- Asserted at an edge: wp, rp, count, output register valid, and flags go to reset values at that edge.
- Push or pop attempts during a flush cycle are dropped. Handshakes cannot complete because din_rdy = 0 and dout_vld = 0 that cycle.

Reset
- At an edge with rst = 1: wp = rp = 0, count = 0, output register valid = 0.
- Output values: din_rdy = 1, dout_vld = 0, almost_full = (AF_LVL == 0 ? 1 : 0) (effectively 0), almost_empty = 1.
- Reset mid-stream discards all contents.
- rst has priority over flush.
- Storage contents are not reset; dout is don't-care while dout_vld = 0.

Test Plan:
- DEPTH=5, OUT_REG=0: push 0x11..0x15 with no pops -> count 1..5; din_rdy = 0 after the 5th push; almost_full = 1 from count 3 (AF_LVL=3). Pop all -> 0x11..0x15 in order; almost_empty = 1 at count <= 1.
- DEPTH=5: continuous push+pop of 0x00..0x1F with dout_rdy = 1 -> ordered output across 6 pointer wraps; count stays at 1 after priming.
- Full FIFO (count 5) with din_vld = 1 and dout_rdy = 1 for one cycle -> one pop, no push; count = 4 after the edge; the next cycle accepts the push.
- OUT_REG=1: push 0xA5 at edge N -> dout_vld = 0 after edge N, dout_vld = 1 with dout = 0xA5 after edge N+1. Hold dout_rdy = 0 for 3 cycles -> dout stable at 0xA5.
- Count 3, assert flush for one cycle together with din_vld = 1 -> din_rdy = 0 during flush; after the edge count = 0, dout_vld = 0, almost_empty = 1. The next push of 0x7E is the first word out.
- Assert rst mid-stream at count 4 with din_vld = 1 -> after the edge count = 0, dout_vld = 0, din_rdy = 1. Subsequent push/pop order is correct.

Source files
------------

// File: rtl/stream_fifo.sv
// stream_fifo: synchronous FIFO with valid/ready handshakes on both sides,
// used to buffer streams between codec pipeline stages.
//
// Any DEPTH >= 2 is supported, including non-powers of two. Full and empty
// are derived from the occupancy register, so the pointers simply wrap at
// DEPTH-1.
//
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   flush         synchronous discard of all contents
//   din/din_vld   write data and request; din_rdy means space is available
//   dout/dout_vld head entry; a pop occurs on dout_vld & dout_rdy
//   count         entries held, 0..DEPTH (includes the output register)
//   almost_full   registered, count >= AF_LVL
//   almost_empty  registered, count <= AE_LVL
module stream_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int OUT_REG    = 0,
  parameter int AF_LVL     = DEPTH - 2,
  parameter int AE_LVL     = 1,
  localparam int AW        = $clog2(DEPTH),
  localparam int CW        = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_vld,
  output logic                  din_rdy,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_vld,
  input  logic                  dout_rdy,
  output logic [CW-1:0]         count,
  output logic                  almost_full,
  output logic                  almost_empty
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wp, rp;
  logic [CW-1:0]         cnt_nxt;
  logic                  push, pop, rd_adv;

  // A pop in the same cycle never frees a slot for a push when full.
  assign din_rdy = (count != CW'(DEPTH)) & ~flush;
  assign push    = din_vld & din_rdy;

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic                  ovld;
      logic [DATA_WIDTH-1:0] oreg;
      logic                  st_ne;

      // Words still in storage = count minus the one held in the output reg.
      assign st_ne    = count > {{(CW-1){1'b0}}, ovld};
      assign dout_vld = ovld & ~flush;
      assign pop      = dout_vld & dout_rdy;
      // Prefetch whenever the output reg is empty or being drained.
      assign rd_adv   = (~ovld | pop) & st_ne & ~flush;
      assign dout     = oreg;

      always_ff @(posedge clk) begin
        if (rst || flush) ovld <= 1'b0;
        else if (~ovld | pop) ovld <= st_ne;
      end

      always_ff @(posedge clk) begin
        if (rd_adv) oreg <= mem[rp];
      end
    end else begin : g_comb
      assign dout_vld = (count != '0) & ~flush;
      assign pop      = dout_vld & dout_rdy;
      assign rd_adv   = pop;
      assign dout     = mem[rp];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= din;
  end

  always_comb begin
    cnt_nxt = count;
    if (rst || flush)     cnt_nxt = '0;
    else if (push & ~pop) cnt_nxt = count + CW'(1);
    else if (pop & ~push) cnt_nxt = count - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push)   wp <= (wp == AW'(DEPTH - 1)) ? '0 : wp + AW'(1);
      if (rd_adv) rp <= (rp == AW'(DEPTH - 1)) ? '0 : rp + AW'(1);
    end
  end

  // Flags are computed from next-count so they move on the same edge as count.
  always_ff @(posedge clk) begin
    if (rst) begin
      count        <= '0;
      almost_full  <= (AF_LVL == 0);
      almost_empty <= 1'b1;
    end else begin
      count        <= cnt_nxt;
      almost_full  <= (cnt_nxt >= CW'(AF_LVL));
      almost_empty <= (cnt_nxt <= CW'(AE_LVL));
    end
  end

endmodule
